// File: rtl/p2p_link.sv
// Bidirectional point-to-point link: two independent valid/ready channels (A->B and B->A),
// each buffered by a DEPTH-entry first-word-fall-through FIFO with delivery counters.
module p2p_link #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         a_tx_data,
  input  logic                     a_tx_valid,
  output logic                     a_tx_ready,
  output logic [WIDTH-1:0]         b_rx_data,
  output logic                     b_rx_valid,
  input  logic                     b_rx_ready,
  input  logic [WIDTH-1:0]         b_tx_data,
  input  logic                     b_tx_valid,
  output logic                     b_tx_ready,
  output logic [WIDTH-1:0]         a_rx_data,
  output logic                     a_rx_valid,
  input  logic                     a_rx_ready,
  output logic [CNT_W-1:0]         ab_count,
  output logic [CNT_W-1:0]         ba_count,
  output logic [$clog2(DEPTH):0]   ab_level,
  output logic [$clog2(DEPTH):0]   ba_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  // Channel index 0 is A->B, index 1 is B->A.
  logic [WIDTH-1:0] mem_q   [2][DEPTH];
  logic [PW-1:0]    wptr_q  [2];
  logic [PW-1:0]    rptr_q  [2];
  logic [LW-1:0]    level_q [2];
  logic [CNT_W-1:0] count_q [2];
  // Holds tx_ready low through reset and until the first edge after it is released.
  logic             up_q;

  logic [WIDTH-1:0] tx_data [2];
  logic [1:0]       tx_valid, tx_ready, rx_valid, rx_ready, push, pop;

  assign tx_data[0]  = a_tx_data;
  assign tx_data[1]  = b_tx_data;
  assign tx_valid[0] = a_tx_valid;
  assign tx_valid[1] = b_tx_valid;
  assign rx_ready[0] = b_rx_ready;
  assign rx_ready[1] = a_rx_ready;

  always_comb begin
    tx_ready = '0;
    rx_valid = '0;
    push     = '0;
    pop      = '0;
    for (int c = 0; c < 2; c++) begin
      tx_ready[c] = up_q && (level_q[c] != LW'(DEPTH));
      rx_valid[c] = (level_q[c] != '0);
      push[c]     = tx_valid[c] && tx_ready[c];
      pop[c]      = rx_valid[c] && rx_ready[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        level_q[c] <= '0;
        count_q[c] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[c][i] <= '0;
        end
      end
    end else begin
      up_q <= 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem_q[c][wptr_q[c]] <= tx_data[c];
          wptr_q[c]           <= wptr_q[c] + PW'(1);
        end
        if (pop[c]) begin
          rptr_q[c]  <= rptr_q[c] + PW'(1);
          count_q[c] <= count_q[c] + CNT_W'(1);
        end
        level_q[c] <= level_q[c] + LW'(push[c]) - LW'(pop[c]);
      end
    end
  end

  assign a_tx_ready = tx_ready[0];
  assign b_rx_valid = rx_valid[0];
  assign b_rx_data  = mem_q[0][rptr_q[0]];
  assign b_tx_ready = tx_ready[1];
  assign a_rx_valid = rx_valid[1];
  assign a_rx_data  = mem_q[1][rptr_q[1]];
  assign ab_count   = count_q[0];
  assign ba_count   = count_q[1];
  assign ab_level   = level_q[0];
  assign ba_level   = level_q[1];

endmodule

// File: doc/p2p_link.md
Name: p2p_link

Overview:
- Parametrised bidirectional point-to-point interconnect between two endpoints, A and B.
- Replaces free-running, unhandshaked message exchange with two independent buffered channels, A->B and B->A.
- Each channel uses a valid/ready handshake on both sides and a DEPTH-entry FIFO.
- Per-direction delivered-message counters and occupancy levels are exported for the bench and for debug.

Parameters:
- WIDTH, 4, message width in bits (>=1).
- DEPTH, 4, FIFO entries per direction; power of 2, >=2.
- CNT_W, 16, width of the delivered-message counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_tx_data  in  WIDTH  message from A to B.
- a_tx_valid  in  1  A offers a_tx_data.
- a_tx_ready  out  1  A->B channel can accept.
- b_rx_data  out  WIDTH  head of the A->B FIFO.
- b_rx_valid  out  1  A->B FIFO non-empty.
- b_rx_ready  in  1  B consumes the head.
- b_tx_data  in  WIDTH  message from B to A.
- b_tx_valid  in  1  B offers b_tx_data.
- b_tx_ready  out  1  B->A channel can accept.
- a_rx_data  out  WIDTH  head of the B->A FIFO.
- a_rx_valid  out  1  B->A FIFO non-empty.
- a_rx_ready  in  1  A consumes the head.
- ab_count  out  CNT_W  messages delivered A->B (popped at B).
- ba_count  out  CNT_W  messages delivered B->A (popped at A).
- ab_level  out  $clog2(DEPTH)+1  current A->B occupancy, 0..DEPTH.
- ba_level  out  $clog2(DEPTH)+1  current B->A occupancy, 0..DEPTH.

Behaviour:
- The two directions are identical and fully independent. The rules below are stated for A->B; B->A mirrors them.
- Reset:
  - While rst=1 at a clk edge: pointers, level, count and storage-valid state clear.
  - Reset values: a_tx_ready=0, b_rx_valid=0, b_rx_data=0, ab_level=0, ab_count=0.
  - All handshake inputs are ignored while rst=1.
  - The first cycle after rst falls: a_tx_ready=1.
  - Reset mid-operation discards all buffered messages; no message is delivered after reset unless it was pushed after reset.
- Push: a_tx_valid && a_tx_ready at the edge writes a_tx_data at the write pointer.
  - a_tx_ready = !full, derived combinationally from registered level only; it does not depend on b_rx_ready.
- Pop: b_rx_valid && b_rx_ready at the edge advances the read pointer and increments ab_count.
  - b_rx_valid = (level != 0).
  - b_rx_data = storage[read pointer] (first-word-fall-through); it is stable while b_rx_valid=1 and no pop occurs.
- Latency: a message pushed at edge N appears on b_rx_data with b_rx_valid=1 in the cycle after edge N. There is no combinational bypass from tx to rx.
- Ordering: strict FIFO, with no loss and no duplication.
- Level update: level += push - pop. A simultaneous push and pop leaves level unchanged; both pointers advance.
- Full (level=DEPTH):
  - a_tx_ready=0, so no push is possible even if a pop occurs in the same cycle.
  - a_tx_ready returns to 1 the cycle after the pop.
- Empty (level=0): b_rx_valid=0; a b_rx_ready assertion has no effect and ab_count does not change.
- Wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH. ab_count wraps from 2^CNT_W-1 to 0 silently.
- Protocol assumption on sources: a_tx_valid is held with stable data until accepted. The block does not check this, but correct operation is required only under it.
- Outputs: all outputs other than a_tx_ready/b_rx_valid/b_rx_data are registered. Those three are decoded from registered state only.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> during rst, tx_ready=0, rx_valid=0, levels=0, counts=0; first cycle after, a_tx_ready=b_tx_ready=1.
- Single message: push a_tx_data=4'hA at edge N with b_rx_ready=0 -> b_rx_valid=1 and b_rx_data=4'hA from cycle N+1; ab_level=1. Assert b_rx_ready=1 for one edge -> ab_count=1, b_rx_valid=0, ab_level=0.
- Fill and order: push 1,2,3,4 with b_rx_ready=0 -> ab_level=4, a_tx_ready=0; a 5th offer (4'h5) is held off. Drain with b_rx_ready=1 -> order 1,2,3,4 out; a_tx_ready=1 the cycle after the first pop; 4'h5 is then accepted and delivered 5th.
- Simultaneous push/pop at level=2 -> level stays 2; the output sequence is continuous. Run 20 back-to-back pushes with b_rx_ready=1 -> ab_count=20 and level never exceeds 1.
- Bidirectional independence: hold B->A full (a_rx_ready=0) while streaming 8 messages A->B -> A->B delivers all 8 in order; ba_level stays 4; b_tx_ready=0 throughout.
- Reset mid-operation: with ab_level=3, assert rst for 1 cycle -> ab_level=0, b_rx_valid=0, ab_count=0. The next push of 4'h7 is the first word delivered.
